// File: rtl/bt_pipe_in_source_if.sv
// Pipe-in source handshake bundle: control/status plus the pipe-in endpoint side.
// master = the source block (drives ep_* and status), slave = host logic and consumer.
// inject_err exists only when BTPIPE_SRC_ERR_INJECT_EN is defined.
interface bt_pipe_in_source_if;
    logic        start;
    logic [15:0] num_blocks;
    logic        mode;
    logic        ep_ready;
    logic        ep_blockstrobe;
    logic        ep_write;
    logic [15:0] ep_dataout;
    logic        busy;
    logic        done;
    logic [15:0] blocks_sent;
`ifdef BTPIPE_SRC_ERR_INJECT_EN
    logic        inject_err;

    modport master (
        input  start, num_blocks, mode, ep_ready, inject_err,
        output ep_blockstrobe, ep_write, ep_dataout, busy, done, blocks_sent
    );
    modport slave (
        output start, num_blocks, mode, ep_ready, inject_err,
        input  ep_blockstrobe, ep_write, ep_dataout, busy, done, blocks_sent
    );
`else
    modport master (
        input  start, num_blocks, mode, ep_ready,
        output ep_blockstrobe, ep_write, ep_dataout, busy, done, blocks_sent
    );
    modport slave (
        output start, num_blocks, mode, ep_ready,
        input  ep_blockstrobe, ep_write, ep_dataout, busy, done, blocks_sent
    );
`endif
endinterface

// File: rtl/bt_pipe_in_source.sv
// Block-throttled pipe-in source: sends num_blocks blocks of LFSR/counter words, one block per ep_ready grant.
// Latency: start@T -> busy@T+1, strobe@T+2, first write@T+3 when ep_ready is already high.
// Backpressure: ep_ready is sampled only at block boundaries; a started block always runs to completion.
// Optional BTPIPE_SRC_ERR_INJECT_EN adds inject_err, which flips bit 0 of the next written word.
module bt_pipe_in_source #(
    parameter int BLOCK_LEN  = 256,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    bt_pipe_in_source_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STROBE   = 3'd2,
        BURST    = 3'd3,
        GAP      = 3'd4,
        FIN      = 3'd5
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(BLOCK_LEN - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] num_blocks_q;
    logic        mode_q;
    logic [31:0] lfsr;
    logic [15:0] cnt;
    logic [15:0] word_idx;
    logic [7:0]  gap_cnt;
    logic [15:0] blocks_sent_q;
    logic        write_q;
    logic [15:0] data_q;
    logic        lfsr_fb;
    logic        last_word;
    logic        last_block;
    logic        inj;
    logic [15:0] gen_word;
    logic        accept_start;

    assign lfsr_fb      = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    assign gen_word     = mode_q ? cnt : lfsr[15:0];
    assign last_word    = (state == BURST) && (word_idx == LAST_IDX);
    // 17-bit compare so num_blocks = 16'hFFFF terminates without wrapping blocks_sent.
    assign last_block   = (({1'b0, blocks_sent_q} + 17'd1) == {1'b0, num_blocks_q});
    assign accept_start = (state == IDLE) && bus.start;

`ifdef BTPIPE_SRC_ERR_INJECT_EN
    assign inj = bus.inject_err;
`else
    assign inj = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start outside IDLE is ignored by construction.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.num_blocks == 16'd0) ? FIN : WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus.ep_ready) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                next_state = BURST;
            end
            BURST: begin
                if (last_word) begin
                    if (last_block) begin
                        next_state = FIN;
                    end else if (GAP_CYCLES == 0) begin
                        next_state = WAIT_RDY;
                    end else begin
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = WAIT_RDY;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transfer configuration latch and data generator; reseeded only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_blocks_q <= 16'd0;
            mode_q       <= 1'b0;
            lfsr         <= 32'h0000_0001;
            cnt          <= 16'h0001;
        end else if (accept_start) begin
            num_blocks_q <= bus.num_blocks;
            mode_q       <= bus.mode;
            lfsr         <= 32'h0000_0001;
            cnt          <= 16'h0001;
        end else if (next_state == BURST) begin
            if (mode_q) begin
                cnt <= cnt + 16'd1;
            end else begin
                lfsr <= {lfsr[30:0], lfsr_fb};
            end
        end
    end

    // Word/data registers: loaded from the generator whenever the next cycle is a write cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            data_q  <= 16'd0;
        end else if (next_state == BURST) begin
            write_q <= 1'b1;
            data_q  <= gen_word ^ {15'd0, inj};
        end else begin
            write_q <= 1'b0;
        end
    end

    // In-block word index, gap timer and completed-block count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx      <= 16'd0;
            gap_cnt       <= 8'd0;
            blocks_sent_q <= 16'd0;
        end else begin
            word_idx <= (state == BURST && !last_word) ? word_idx + 16'd1 : 16'd0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
            if (accept_start) begin
                blocks_sent_q <= 16'd0;
            end else if (last_word) begin
                blocks_sent_q <= blocks_sent_q + 16'd1;
            end
        end
    end

    assign bus.ep_blockstrobe = (state == STROBE);
    assign bus.ep_write       = write_q;
    assign bus.ep_dataout     = data_q;
    assign bus.busy           = (state == WAIT_RDY) || (state == STROBE) ||
                                (state == BURST) || (state == GAP);
    assign bus.done           = (state == FIN);
    assign bus.blocks_sent    = blocks_sent_q;

endmodule

// File: tb/tb_bt_pipe_in_source.sv
// Directed bench for bt_pipe_in_source with BLOCK_LEN=4, GAP_CYCLES=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Define BTPIPE_SRC_ERR_INJECT_EN to also exercise inject_err.
module tb_bt_pipe_in_source;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bt_pipe_in_source_if bus ();

    bt_pipe_in_source #(.BLOCK_LEN(4), .GAP_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.num_blocks = 16'd0;
        bus.mode       = 1'b0;
        bus.ep_ready   = 1'b1;
`ifdef BTPIPE_SRC_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        n_cmp++;
        if ({bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b expected 0000",
                     {bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done});
        end
        n_cmp++;
        if ({bus.ep_dataout, bus.blocks_sent} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 00000000", {bus.ep_dataout, bus.blocks_sent});
        end
        // start together with reset must be ignored
        bus.start = 1'b1;
        bus.num_blocks = 16'd1;
        tick();
        bus.start = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_counter_two_blocks();
        logic        e_stb, e_wr, e_busy, e_done;
        logic [15:0] e_dat;
        bus.start = 1'b1; bus.num_blocks = 16'd2; bus.mode = 1'b1; bus.ep_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            bus.start = 1'b0;
            e_stb  = (k == 2) || (k == 10);
            e_wr   = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
            e_dat  = (k <= 6) ? 16'(k - 2) : 16'(k - 6);
            e_busy = (k <= 14);
            e_done = (k == 15);
            n_cmp++;
            if ({bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done} !== {e_stb, e_wr, e_busy, e_done}) begin
                n_err++;
                $display("FAIL cnt2_ctl T+%0d: got %b expected %b", k,
                         {bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done},
                         {e_stb, e_wr, e_busy, e_done});
            end
            if (e_wr) begin
                n_cmp++;
                if (bus.ep_dataout !== e_dat) begin
                    n_err++;
                    $display("FAIL cnt2_data T+%0d: got %h expected %h", k, bus.ep_dataout, e_dat);
                end
            end
        end
        n_cmp++;
        if (bus.blocks_sent !== 16'd2) begin
            n_err++;
            $display("FAIL cnt2_blocks_sent: got %0d expected 2", bus.blocks_sent);
        end
    endtask

    task automatic test_lfsr();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h0001; exp_w[1] = 16'h0003; exp_w[2] = 16'h0006; exp_w[3] = 16'h000D;
        bus.start = 1'b1; bus.num_blocks = 16'd1; bus.mode = 1'b0; bus.ep_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            bus.start = 1'b0;
            if (k >= 3 && k <= 6) begin
                n_cmp++;
                if (bus.ep_write !== 1'b1 || bus.ep_dataout !== exp_w[k-3]) begin
                    n_err++;
                    $display("FAIL lfsr_word%0d: got wr=%b %h expected wr=1 %h",
                             k - 3, bus.ep_write, bus.ep_dataout, exp_w[k-3]);
                end
            end
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.blocks_sent !== 16'd1) begin
            n_err++;
            $display("FAIL lfsr_done: got done=%b sent=%0d expected done=1 sent=1",
                     bus.done, bus.blocks_sent);
        end
        tick();
    endtask

    task automatic test_ready_throttle();
        int bad;
        bus.start = 1'b1; bus.num_blocks = 16'd1; bus.mode = 1'b1; bus.ep_ready = 1'b0;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            bus.start = 1'b0;
            if (bus.ep_blockstrobe !== 1'b0 || bus.ep_write !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL throttle_hold: got %0d active cycles expected 0", bad);
        end
        bus.ep_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.ep_blockstrobe !== 1'b1 || bus.ep_write !== 1'b0) begin
            n_err++;
            $display("FAIL throttle_strobe: got stb=%b wr=%b expected stb=1 wr=0",
                     bus.ep_blockstrobe, bus.ep_write);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.ep_ready = 1'b0;
            n_cmp++;
            if (bus.ep_write !== 1'b1 || bus.ep_dataout !== 16'(k)) begin
                n_err++;
                $display("FAIL throttle_word%0d: got wr=%b %h expected wr=1 %h",
                         k, bus.ep_write, bus.ep_dataout, 16'(k));
            end
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL throttle_done: got %b expected 1", bus.done);
        end
        bus.ep_ready = 1'b1;
        tick();
    endtask

    task automatic test_zero_blocks();
        bus.start = 1'b1; bus.num_blocks = 16'd0; bus.mode = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ep_write !== 1'b0 || bus.blocks_sent !== 16'd0) begin
            n_err++;
            $display("FAIL zero_done: got done=%b busy=%b wr=%b sent=%0d expected 1 0 0 0",
                     bus.done, bus.busy, bus.ep_write, bus.blocks_sent);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_cmp++;
            if ({bus.done, bus.ep_write, bus.ep_blockstrobe, bus.busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL zero_idle T+%0d: got %b expected 0000", k,
                         {bus.done, bus.ep_write, bus.ep_blockstrobe, bus.busy});
            end
        end
    endtask

    task automatic test_start_while_busy();
        bus.start = 1'b1; bus.num_blocks = 16'd1; bus.mode = 1'b1; bus.ep_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            bus.start = (k == 3);
            bus.num_blocks = (k == 3) ? 16'd5 : 16'd1;
            bus.mode = (k == 3) ? 1'b0 : 1'b1;
            if (k >= 3 && k <= 6) begin
                n_cmp++;
                if (bus.ep_write !== 1'b1 || bus.ep_dataout !== 16'(k - 2)) begin
                    n_err++;
                    $display("FAIL busy_start_word%0d: got wr=%b %h expected wr=1 %h",
                             k - 2, bus.ep_write, bus.ep_dataout, 16'(k - 2));
                end
            end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.blocks_sent !== 16'd1) begin
            n_err++;
            $display("FAIL busy_start_done: got done=%b sent=%0d expected done=1 sent=1",
                     bus.done, bus.blocks_sent);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        bus.start = 1'b1; bus.num_blocks = 16'd2; bus.mode = 1'b1; bus.ep_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.start = 1'b0;
        end
        n_cmp++;
        if (bus.ep_write !== 1'b1 || bus.ep_dataout !== 16'h0003) begin
            n_err++;
            $display("FAIL midrst_third: got wr=%b %h expected wr=1 0003", bus.ep_write, bus.ep_dataout);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done, bus.ep_dataout, bus.blocks_sent} !== 36'd0) begin
            n_err++;
            $display("FAIL midrst_async: got %h expected 000000000",
                     {bus.ep_blockstrobe, bus.ep_write, bus.busy, bus.done, bus.ep_dataout, bus.blocks_sent});
        end
        tick();
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.ep_write !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones);
        end
        bus.start = 1'b1; bus.num_blocks = 16'd1; bus.mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            bus.start = 1'b0;
        end
        n_cmp++;
        if (bus.ep_write !== 1'b1 || bus.ep_dataout !== 16'h0001) begin
            n_err++;
            $display("FAIL midrst_reseed: got wr=%b %h expected wr=1 0001", bus.ep_write, bus.ep_dataout);
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

`ifdef BTPIPE_SRC_ERR_INJECT_EN
    task automatic test_inject();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h0001; exp_w[1] = 16'h0002; exp_w[2] = 16'h0002; exp_w[3] = 16'h0004;
        bus.start = 1'b1; bus.num_blocks = 16'd1; bus.mode = 1'b1; bus.ep_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.start = 1'b0;
            // inject during the cycle that loads the third word
            bus.inject_err = (k == 4);
            if (k >= 3) begin
                n_cmp++;
                if (bus.ep_dataout !== exp_w[k-3]) begin
                    n_err++;
                    $display("FAIL inject_word%0d: got %h expected %h", k - 3, bus.ep_dataout, exp_w[k-3]);
                end
            end
        end
        bus.inject_err = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_counter_two_blocks();
        tick();
        test_lfsr();
        test_ready_throttle();
        test_zero_blocks();
        test_start_while_busy();
        test_reset_mid_burst();
`ifdef BTPIPE_SRC_ERR_INJECT_EN
        test_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
